// File: rtl/sprite_arbiter.sv
// sprite_arbiter: two-sprite hit test, priority arbitration, shared-ROM addressing and colour-key compositing.
// Optional feature macro: SPR_ARB_MIRROR_EN enables per-sprite horizontal mirroring.
`default_nettype none

module sprite_arbiter #(
  parameter int         ADDR_W   = 14,
  parameter logic [5:0] KEY_RGB  = 6'b110011,
  parameter int         SCALE_SH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic [9:0]            col,
  input  logic [9:0]            row,
  input  logic [19:0]           spr_x,
  input  logic [19:0]           spr_y,
  input  logic [13:0]           spr_w,
  input  logic [13:0]           spr_h,
  input  logic [2*ADDR_W-1:0]   spr_base,
  input  logic [15:0]           spr_stride,
  input  logic [1:0]            spr_en,
  input  logic [1:0]            spr_mirror,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [5:0]            rom_rgb,
  input  logic [5:0]            bg_rgb,
  output logic [5:0]            pix_rgb
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_S0   = 2'd1,
    GNT_S1   = 2'd2
  } grant_t;

  // Descriptor shadows: frozen between frame ticks so mid-frame writes never tear a sprite.
  logic [1:0]              sh_en;
  logic [1:0][9:0]         sh_x;
  logic [1:0][9:0]         sh_y;
  logic [1:0][6:0]         sh_w;
  logic [1:0][6:0]         sh_h;
  logic [1:0][ADDR_W-1:0]  sh_base;
  logic [1:0][7:0]         sh_stride;
`ifdef SPR_ARB_MIRROR_EN
  logic [1:0]              sh_mirror;
`else
  logic                    unused_mirror;
  assign unused_mirror = ^spr_mirror;
`endif

  logic [1:0]      hit;
  logic [1:0][6:0] lx;
  logic [1:0][6:0] ly;

  for (genvar i = 0; i < 2; i++) begin : g_spr
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;

    // 11-bit ends so a sprite touching the right/bottom edge cannot wrap to zero.
    assign x_end  = {1'b0, sh_x[i]} + (11'(sh_w[i]) << SCALE_SH);
    assign y_end  = {1'b0, sh_y[i]} + (11'(sh_h[i]) << SCALE_SH);
    assign hit[i] = sh_en[i]
                  && (col >= sh_x[i]) && ({1'b0, col} < x_end)
                  && (row >= sh_y[i]) && ({1'b0, row} < y_end);
    assign dx     = col - sh_x[i];
    assign dy     = row - sh_y[i];
    assign lx[i]  = 7'(dx >> SCALE_SH);
    assign ly[i]  = 7'(dy >> SCALE_SH);
  end

  grant_t              grant;
  logic                sel;
  logic [6:0]          lx_eff;
  logic [ADDR_W-1:0]   addr_next;

  always_comb begin
    grant     = GNT_NONE;
    sel       = 1'b0;
    lx_eff    = '0;
    addr_next = '0;
    if (hit[0]) begin
      grant = GNT_S0;
    end else if (hit[1]) begin
      grant = GNT_S1;
      sel   = 1'b1;
    end
`ifdef SPR_ARB_MIRROR_EN
    lx_eff = sh_mirror[sel] ? 7'(sh_w[sel] - 7'd1 - lx[sel]) : lx[sel];
`else
    lx_eff = lx[sel];
`endif
    // Modular ADDR_W-bit arithmetic gives the same result as truncating a full-width sum.
    addr_next = sh_base[sel]
              + ADDR_W'(ly[sel]) * ADDR_W'(sh_stride[sel])
              + ADDR_W'(lx_eff);
  end

  grant_t gnt_q1;
  grant_t gnt_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en     <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_w      <= '0;
      sh_h      <= '0;
      sh_base   <= '0;
      sh_stride <= '0;
`ifdef SPR_ARB_MIRROR_EN
      sh_mirror <= '0;
`endif
      rom_addr  <= '0;
      gnt_q1    <= GNT_NONE;
      gnt_q2    <= GNT_NONE;
      pix_rgb   <= '0;
    end else begin
      if (frame_tick) begin
        sh_en     <= spr_en;
        sh_x      <= spr_x;
        sh_y      <= spr_y;
        sh_w      <= spr_w;
        sh_h      <= spr_h;
        sh_base   <= spr_base;
        sh_stride <= spr_stride;
`ifdef SPR_ARB_MIRROR_EN
        sh_mirror <= spr_mirror;
`endif
      end
      rom_addr <= (grant == GNT_NONE) ? '0 : addr_next;
      gnt_q1   <= grant;
      gnt_q2   <= gnt_q1;
      // gnt_q2 lines up with the ROM data returned for the address issued one cycle earlier.
      if ((gnt_q2 != GNT_NONE) && (rom_rgb != KEY_RGB)) begin
        pix_rgb <= rom_rgb;
      end else begin
        pix_rgb <= bg_rgb;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_arbiter.sv
// Directed self-checking bench for sprite_arbiter (default parameters).
`default_nettype none

module tb_sprite_arbiter;

  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic [9:0]      col, row;
  logic [19:0]     spr_x, spr_y;
  logic [13:0]     spr_w, spr_h;
  logic [2*AW-1:0] spr_base;
  logic [15:0]     spr_stride;
  logic [1:0]      spr_en, spr_mirror;
  logic [AW-1:0]   rom_addr;
  logic [5:0]      rom_rgb, bg_rgb, pix_rgb;

  int checks = 0;
  int errors = 0;

  sprite_arbiter dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .col(col), .row(row),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_base(spr_base), .spr_stride(spr_stride), .spr_en(spr_en),
    .spr_mirror(spr_mirror), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .bg_rgb(bg_rgb), .pix_rgb(pix_rgb)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Hold a coordinate: address appears one edge later, pixel three edges later.
  task automatic probe(input string tag, input int c, input int r,
                       input logic [31:0] exp_addr, input logic [31:0] exp_pix);
    col = 10'(c);
    row = 10'(r);
    tick(1);
    check({tag, "_addr"}, 32'(rom_addr), exp_addr);
    tick(2);
    check({tag, "_pix"}, 32'(pix_rgb), exp_pix);
  endtask

  task automatic do_frame_tick();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
  endtask

  task automatic set_spr0_main();
    spr_x[9:0] = 10'd100;  spr_y[9:0] = 10'd50;
    spr_w[6:0] = 7'd23;    spr_h[6:0] = 7'd30;
    spr_stride[7:0] = 8'd69; spr_base[AW-1:0] = '0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; col = '0; row = '0;
    spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_base = '0; spr_stride = '0;
    spr_en = '0; spr_mirror = '0; rom_rgb = 6'h0F; bg_rgb = 6'h05;
    tick(2);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_pix", 32'(pix_rgb), 32'd0);
    rst = 1'b0;

    // Descriptors present but never ticked in: nothing may be drawn.
    set_spr0_main();
    spr_x[19:10] = 10'd100; spr_y[19:10] = 10'd50;
    spr_w[13:7] = 7'd23; spr_h[13:7] = 7'd30; spr_stride[15:8] = 8'd69;
    spr_en = 2'b11;
    for (int i = 0; i < 6; i++) begin
      probe("sweep_no_tick", 98 + 4 * i, 54, 32'd0, 32'd5);
    end

    spr_en = 2'b01;
    col = '0; row = '0;
    do_frame_tick();
    // Single-cycle coordinate to prove the exact 3-cycle latency.
    col = 10'd102; row = 10'd54;
    tick(1);
    check("lat_addr_n1", 32'(rom_addr), 32'd139);
    col = '0;
    tick(1);
    check("lat_addr_n2", 32'(rom_addr), 32'd0);
    check("lat_pix_n2", 32'(pix_rgb), 32'd5);
    tick(1);
    check("lat_pix_n3", 32'(pix_rgb), 32'h0F);
    tick(1);
    check("lat_pix_n4", 32'(pix_rgb), 32'd5);

    probe("edge_topleft", 100, 50, 32'd0, 32'h0F);
    probe("edge_right_in", 145, 50, 32'd22, 32'h0F);
    probe("edge_right_out", 146, 50, 32'd0, 32'd5);
    probe("edge_bottom_in", 100, 109, 32'd2001, 32'h0F);
    probe("edge_bottom_out", 100, 110, 32'd0, 32'd5);
    probe("edge_left_out", 99, 54, 32'd0, 32'd5);

    spr_mirror = 2'b01;
    do_frame_tick();
`ifdef SPR_ARB_MIRROR_EN
    probe("mirror", 102, 54, 32'd159, 32'h0F);
`else
    probe("mirror", 102, 54, 32'd139, 32'h0F);
`endif
    spr_mirror = 2'b00;
    do_frame_tick();

    // Descriptor change without a tick must not move the sprite.
    spr_x[9:0] = 10'd300;
    probe("move_pending_old", 102, 54, 32'd139, 32'h0F);
    probe("move_pending_new", 302, 54, 32'd0, 32'd5);
    do_frame_tick();
    probe("move_done_new", 302, 54, 32'd139, 32'h0F);
    probe("move_done_old", 102, 54, 32'd0, 32'd5);

    // Overlap at (200,200): sprite 0 -> 1000+5*40+5, sprite 1 -> 3000+2*16+2.
    spr_x[9:0] = 10'd190; spr_y[9:0] = 10'd190; spr_w[6:0] = 7'd20; spr_h[6:0] = 7'd20;
    spr_stride[7:0] = 8'd40; spr_base[AW-1:0] = 14'd1000;
    spr_x[19:10] = 10'd195; spr_y[19:10] = 10'd195; spr_w[13:7] = 7'd10; spr_h[13:7] = 7'd10;
    spr_stride[15:8] = 8'd16; spr_base[2*AW-1:AW] = 14'd3000;
    spr_en = 2'b11;
    do_frame_tick();
    probe("overlap_s0", 200, 200, 32'd1205, 32'h0F);
    spr_en = 2'b10;
    do_frame_tick();
    probe("overlap_s1", 200, 200, 32'd3034, 32'h0F);

    spr_en = 2'b11;
    do_frame_tick();
    rom_rgb = 6'b110011;
    probe("key_transparent", 200, 200, 32'd1205, 32'd5);
    rom_rgb = 6'b000011;
    probe("key_opaque", 200, 200, 32'd1205, 32'd3);

    // Mid-line reset: pipeline flushed, shadow enables cleared.
    rst = 1'b1;
    tick(1);
    check("midrst_addr", 32'(rom_addr), 32'd0);
    check("midrst_pix", 32'(pix_rgb), 32'd0);
    rst = 1'b0;
    probe("post_rst_nodraw", 200, 200, 32'd0, 32'd5);
    do_frame_tick();
    probe("post_rst_tick", 200, 200, 32'd1205, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
